key_debounce: RTL and testbench
===============================

# key_debounce

Pushbutton conditioning stage feeding the LED blinker's `reset` and control inputs. It synchronises a raw board key to `CLOCK_50`, rejects contact bounce with a stability counter and presents a clean level. It also emits single-cycle press and release strobes, so downstream counters can act on a button without metastability or multiple triggers.

## Interface

Parameters:
- `STABLE_CYCLES`, default 500000: consecutive stable cycles required to accept a new key state; 10 ms at 50 MHz. Legal range 2..2^24−1.
- `KEY_ACTIVE_LOW`, default 1: 1 means the raw key reads 0 when pressed, as on DE-series boards; 0 means the key reads 1 when pressed.

Ports:
- `CLOCK_50`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `key_raw`, input, 1: raw asynchronous pushbutton pin.
- `key_level`, output, 1: debounced state; 1 means pressed.
- `key_press`, output, 1: one-cycle strobe when `key_level` goes 0→1.
- `key_release`, output, 1: one-cycle strobe when `key_level` goes 1→0.
- `key_toggle`, output, 1: flips on each accepted press. Present only with `KEY_DEBOUNCE_TOGGLE_EN`; otherwise tied to 0.

## Operation

- Input stage:
  - Two-flop synchroniser on `key_raw`.
  - Its output is normalised to `pressed_s` (1 = pressed) according to `KEY_ACTIVE_LOW`.
- FSM states: `REL` (released, stable), `WAIT_P` (candidate press), `PRS` (pressed, stable), `WAIT_R` (candidate release).
- Transitions (`cnt` is the stability counter, width ⌈log2(STABLE_CYCLES+1)⌉):
  - `REL`: if `pressed_s`=1, go to `WAIT_P` and set `cnt`=1.
  - `WAIT_P`:
    - `pressed_s`=0 (bounce): go to `REL`, `cnt`=0.
    - `pressed_s`=1 and `cnt`=STABLE_CYCLES−1: go to `PRS`, `cnt`=0.
    - Otherwise, `cnt`+1.
  - `PRS`: if `pressed_s`=0, go to `WAIT_R` and set `cnt`=1.
  - `WAIT_R`: symmetric to `WAIT_P`, with the opposite polarity, returning to `PRS` on bounce and going to `REL` on acceptance.
- `cnt` never exceeds STABLE_CYCLES−1 and cannot wrap.
- `key_level` is 1 in `PRS` and `WAIT_R`, and 0 in `REL` and `WAIT_P`. A candidate state never changes the level.
- `key_press` is registered and high for exactly the one cycle after the `WAIT_P`→`PRS` transition. `key_release` behaves the same for `WAIT_R`→`REL`.
- `key_press` and `key_release` are mutually exclusive. Two strobes of the same type are separated by at least 2·STABLE_CYCLES cycles.

## Timing

- Reset (asynchronous assert, synchronous release):
  - Synchroniser flops load the released raw value (1 if `KEY_ACTIVE_LOW`, else 0).
  - State `REL`, `cnt`=0.
  - `key_level`=0, `key_press`=0, `key_release`=0, `key_toggle`=0.
- Latency: a clean edge on `key_raw` before rising edge N gives a `key_level` change and its strobe at edge N+2+STABLE_CYCLES, i.e. 2 synchroniser cycles plus STABLE_CYCLES counting cycles including the entry cycle.
- Bounce: any reversion of `pressed_s` during `WAIT_*` restarts the qualification from scratch. Glitches shorter than STABLE_CYCLES produce no output activity.
- Key held through reset release: treated as a fresh press, so `key_press` fires at cycle 2+STABLE_CYCLES after release.
- Reset asserted mid-qualification or mid-strobe: outputs clear immediately and no strobe is emitted afterwards for the interrupted event.

## Configuration

- `KEY_DEBOUNCE_TOGGLE_EN` defined:
  - Adds a `key_toggle` register that inverts in the same cycle `key_press` is asserted.
  - Gives a push-on/push-off control for the blinker enable.
- Not defined: no toggle register is built, and `key_toggle` is a constant 0.

## Test plan

All scenarios use `STABLE_CYCLES`=8 and `KEY_ACTIVE_LOW`=1.

- Reset with `key_raw`=1, hold 20 cycles → all outputs 0 and state `REL` throughout.
- Clean press (`key_raw` 1→0 before edge 0) → `key_level` rises and `key_press`=1 at edge 10, for one cycle only. `key_release` stays 0.
- Bouncy press: `key_raw` toggles every 3 cycles for 30 cycles, then holds 0 → exactly one `key_press`, 10 cycles after the final edge; no earlier strobes.
- Clean release after a stable press → `key_level` falls and `key_release` pulses once, 10 cycles after `key_raw` returns to 1.
- 7-cycle low glitch on an idle key → no change on any output.
- `reset` asserted at cycle 5 of qualification, released 3 cycles later with key still held → outputs 0 immediately, then `key_press` 10 cycles after release. With `KEY_DEBOUNCE_TOGGLE_EN`, `key_toggle` = 1 after the first press and 0 after the second.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: synchronise, debounce and edge-detect a raw pushbutton.
// Define KEY_DEBOUNCE_TOGGLE_EN to build the push-on/push-off key_toggle register.
module key_debounce #(
    parameter int unsigned STABLE_CYCLES  = 500000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_toggle
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        REL,
        WAIT_P,
        PRS,
        WAIT_R
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_pressed;
    logic          w_level_nxt;
    logic          w_press_nxt;
    logic          w_release_nxt;

    // Synchroniser idles at the released pin level so reset never fakes a press
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_sync1 <= KEY_ACTIVE_LOW;
            r_sync2 <= KEY_ACTIVE_LOW;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = r_sync2 ^ KEY_ACTIVE_LOW;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= REL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            REL: begin
                if (w_pressed) begin
                    w_state_nxt = WAIT_P;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_P: begin
                if (!w_pressed) begin
                    w_state_nxt = REL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRS;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            PRS: begin
                if (!w_pressed) begin
                    w_state_nxt = WAIT_R;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_R: begin
                if (w_pressed) begin
                    w_state_nxt = PRS;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = REL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = REL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Level lags the state by one cycle; strobes fire when the level catches up
    assign w_level_nxt   = (r_state == PRS) || (r_state == WAIT_R);
    assign w_press_nxt   = (r_state == PRS) && !r_level;
    assign w_release_nxt = (r_state == REL) && r_level;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;

`ifdef KEY_DEBOUNCE_TOGGLE_EN
    logic r_toggle;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_toggle <= 1'b0;
        end else if (w_press_nxt) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign key_toggle = r_toggle;
`else
    assign key_toggle = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench for key_debounce with STABLE_CYCLES=8.
// Expected strobes are queued with their cycle stamp when the key is driven.
module tb_key_debounce;

    localparam int S   = 8;
    localparam int LAT = S + 3;
`ifdef KEY_DEBOUNCE_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    typedef struct {
        int cyc;
        bit rel;
    } ev_t;

    logic CLOCK_50 = 1'b0;
    logic reset;
    logic key_raw;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_toggle;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t m_ev;
    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    key_debounce #(
        .STABLE_CYCLES (S),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_toggle (key_toggle)
    );

    always @(posedge CLOCK_50) begin
        #1;
        cyc = cyc + 1;
        if (key_press === 1'b1) begin
            m_ev.cyc = cyc;
            m_ev.rel = 1'b0;
            obs_q.push_back(m_ev);
        end
        if (key_release === 1'b1) begin
            m_ev.cyc = cyc;
            m_ev.rel = 1'b1;
            obs_q.push_back(m_ev);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #2;
        end
    endtask

    task automatic push_exp(input int c, input bit rel);
        ev_t e;
        e.cyc = c;
        e.rel = rel;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        ev_t e;
        ev_t o;
        reset   = 1'b0;
        key_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checks++;
            if ({key_level, key_press, key_release, key_toggle} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold: outputs=%b required 0000 at cyc %0d",
                         {key_level, key_press, key_release, key_toggle}, cyc);
            end
        end
        reset = 1'b1;
        tick(20);
        checks++;
        if (key_level !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_level: got %b required 0", key_level);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL reset_sb: missing rel=%0b at cyc %0d", e.rel, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.rel !== e.rel) begin
                    failures++;
                    $display("FAIL reset_sb: got rel=%0b cyc %0d required rel=%0b cyc %0d",
                             o.rel, o.cyc, e.rel, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_sb_extra: %0d unexpected strobes, first cyc %0d required none",
                     obs_q.size(), obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_clean_press;
        ev_t e;
        ev_t o;
        int  c0;
        key_raw = 1'b0;
        c0      = cyc;
        push_exp(c0 + LAT, 1'b0);
        tick(LAT - 1);
        checks++;
        if (key_level !== 1'b0) begin
            failures++;
            $display("FAIL press_early: level=%b required 0 at cyc %0d", key_level, cyc);
        end
        tick(1);
        checks++;
        if (key_level !== 1'b1 || key_press !== 1'b1 || key_release !== 1'b0) begin
            failures++;
            $display("FAIL press_edge: lvl/prs/rel=%b%b%b required 110",
                     key_level, key_press, key_release);
        end
        tick(1);
        checks++;
        if (key_press !== 1'b0 || key_level !== 1'b1) begin
            failures++;
            $display("FAIL press_width: prs=%b lvl=%b required prs=0 lvl=1", key_press, key_level);
        end
        tick(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL press_sb: missing rel=%0b at cyc %0d", e.rel, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.rel !== e.rel) begin
                    failures++;
                    $display("FAIL press_sb: got rel=%0b cyc %0d required rel=%0b cyc %0d",
                             o.rel, o.cyc, e.rel, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL press_sb_extra: %0d unexpected strobes, first cyc %0d required none",
                     obs_q.size(), obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_clean_release;
        ev_t e;
        ev_t o;
        int  c0;
        key_raw = 1'b1;
        c0      = cyc;
        push_exp(c0 + LAT, 1'b1);
        tick(LAT - 1);
        checks++;
        if (key_level !== 1'b1) begin
            failures++;
            $display("FAIL release_early: level=%b required 1 at cyc %0d", key_level, cyc);
        end
        tick(1);
        checks++;
        if (key_level !== 1'b0 || key_release !== 1'b1 || key_press !== 1'b0) begin
            failures++;
            $display("FAIL release_edge: lvl/prs/rel=%b%b%b required 001",
                     key_level, key_press, key_release);
        end
        tick(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL release_sb: missing rel=%0b at cyc %0d", e.rel, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.rel !== e.rel) begin
                    failures++;
                    $display("FAIL release_sb: got rel=%0b cyc %0d required rel=%0b cyc %0d",
                             o.rel, o.cyc, e.rel, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL release_sb_extra: %0d unexpected strobes, first cyc %0d required none",
                     obs_q.size(), obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_glitch;
        key_raw = 1'b0;
        tick(S - 1);
        key_raw = 1'b1;
        tick(20);
        checks++;
        if (key_level !== 1'b0) begin
            failures++;
            $display("FAIL glitch_level: level=%b required 0", key_level);
        end
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_sb: %0d strobes seen required 0", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_bouncy_press;
        ev_t e;
        ev_t o;
        int  cf;
        for (int i = 0; i < 10; i++) begin
            key_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        key_raw = 1'b0;
        cf      = cyc;
        push_exp(cf + LAT, 1'b0);
        tick(LAT + 4);
        checks++;
        if (key_level !== 1'b1) begin
            failures++;
            $display("FAIL bouncy_level: level=%b required 1", key_level);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL bouncy_sb: missing rel=%0b at cyc %0d", e.rel, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.rel !== e.rel) begin
                    failures++;
                    $display("FAIL bouncy_sb: got rel=%0b cyc %0d required rel=%0b cyc %0d",
                             o.rel, o.cyc, e.rel, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL bouncy_sb_extra: %0d unexpected strobes, first cyc %0d required none",
                     obs_q.size(), obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        ev_t e;
        ev_t o;
        int  c0;
        key_raw = 1'b0;
        tick(7);
        reset = 1'b0;
        #1;
        checks++;
        if ({key_level, key_press, key_release, key_toggle} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_qual: outputs=%b required 0000",
                     {key_level, key_press, key_release, key_toggle});
        end
        tick(3);
        reset = 1'b1;
        c0    = cyc;
        push_exp(c0 + LAT, 1'b0);
        tick(LAT);
        checks++;
        if (key_press !== 1'b1 || key_level !== 1'b1 || key_toggle !== TOG) begin
            failures++;
            $display("FAIL rstmid_press: prs=%b lvl=%b tog=%b required 1 1 %b",
                     key_press, key_level, key_toggle, TOG);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({key_level, key_press, key_release, key_toggle} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_strobe: outputs=%b required 0000",
                     {key_level, key_press, key_release, key_toggle});
        end
        tick(2);
        reset = 1'b1;
        c0    = cyc;
        push_exp(c0 + LAT, 1'b0);
        tick(LAT + 3);
        checks++;
        if (key_toggle !== TOG) begin
            failures++;
            $display("FAIL toggle_first: tog=%b required %b", key_toggle, TOG);
        end
        key_raw = 1'b1;
        c0      = cyc;
        push_exp(c0 + LAT, 1'b1);
        tick(LAT + 2);
        key_raw = 1'b0;
        c0      = cyc;
        push_exp(c0 + LAT, 1'b0);
        tick(LAT + 2);
        checks++;
        if (key_toggle !== 1'b0 || key_level !== 1'b1) begin
            failures++;
            $display("FAIL toggle_second: tog=%b lvl=%b required 0 1", key_toggle, key_level);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL rstmid_sb: missing rel=%0b at cyc %0d", e.rel, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.rel !== e.rel) begin
                    failures++;
                    $display("FAIL rstmid_sb: got rel=%0b cyc %0d required rel=%0b cyc %0d",
                             o.rel, o.cyc, e.rel, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_sb_extra: %0d unexpected strobes, first cyc %0d required none",
                     obs_q.size(), obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    initial begin
        reset   = 1'b0;
        key_raw = 1'b1;
        test_reset();
        test_clean_press();
        test_clean_release();
        test_glitch();
        test_bouncy_press();
        test_clean_release();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
